bcd_key_decoder: RTL and testbench
==================================

# bcd_key_decoder

Receive-side counterpart of the 9-line active-low priority keypad encoder: takes its 4-bit active-low complemented-BCD code and decodes it back into a debounced key state. Drives 10 active-low one-hot lines plus a binary digit, and emits press/release events through a one-deep valid/ready buffer. Flags invalid codes. Sits between the keypad encoder and the key-handling logic.

## Interface
- STABLE_CYCLES, 4, consecutive identical samples required to accept a code (≥2)
- ERR_W, 8, width of the saturating invalid-code counter

- I_clk  input  1  clock, rising edge
- I_rst  input  1  asynchronous, active-high reset
- I_n  input  4  encoder code, active low: digit = ~I_n; 4'b1111 = no key
- O_n  output  10  active-low one-hot of accepted digit; bit k low ⇔ digit k (bit 0 = no key)
- O_digit  output  4  accepted digit, 0..9 (0 = no key)
- O_key_vld  output  1  event pending
- O_key_code  output  4  event digit (1..9 for press; released digit for release)
- O_key_rel  output  1  event is a release
- I_key_rdy  input  1  consumer accepts event
- O_err  output  1  one-cycle pulse: invalid code accepted
- O_err_cnt  output  ERR_W  count of invalid acceptances, saturating
- O_ovf  output  1  sticky: event dropped because buffer was full

## Operation
- Filter: registers cand (4b) and cnt (0..STABLE_CYCLES). Each edge: if I_n ≠ cand → cand←I_n, cnt←1; else if cnt < STABLE_CYCLES → cnt←cnt+1, and if cnt+1 = STABLE_CYCLES → accept(~cand) this edge. cnt saturates, so each stable run accepts once.
- Accept(d), d = ~cand:
  - d > 9: invalid. O_err=1 for one cycle, O_err_cnt+1 (holds at all-ones). Display, state and events unchanged.
  - d = current O_digit: no effect (glitch recovery).
  - else: O_digit←d, O_n←~(1<<d). Event: d≠0 → press(code=d, rel=0); d=0 → release(code=old digit, rel=1).
- Direct key change (5→3, no idle between): single press event for 3, no release.
- FSM: S_IDLE (O_digit=0), S_PRESS (O_digit 1..9). S_IDLE→S_PRESS on valid press; S_PRESS→S_PRESS on direct change; S_PRESS→S_IDLE on release. Invalid codes never change state.
- Event buffer (depth 1): load on event. Handshake completes on edge with O_key_vld & I_key_rdy. Same-edge completion and new event → new event loaded, no overflow. Event while O_key_vld & ~I_key_rdy → new event dropped, old held unchanged, O_ovf←1.
- Reset values: O_n=10'b11_1111_1110, O_digit=0, O_key_vld=0, O_key_code=0, O_key_rel=0, O_err=0, O_err_cnt=0, O_ovf=0, cand=4'b1111, cnt=STABLE_CYCLES, state S_IDLE. Reset therefore produces no spurious release.

## Timing
- Latency: code first sampled at edge E, held → O_n/O_digit/O_key_vld/O_err update after edge E+STABLE_CYCLES−1 (4 edges total at default).
- Any differing sample restarts the count; a one-cycle glitch costs STABLE_CYCLES edges of re-qualification and produces no event if the value returns.
- O_key_code/O_key_rel stable while O_key_vld=1 and ~I_key_rdy.
- I_rst asserted mid-debounce or with an event pending: all state goes to reset values immediately. The pending event is lost and O_ovf is cleared. After I_rst deasserts, the filter requalifies from cand=4'b1111.
- All outputs registered; no combinational path from I_n or I_key_rdy to any output.

## Structure
- Package keydec_pkg: state enum {S_IDLE, S_PRESS}, CODE_NONE=4'b1111, MAX_DIGIT=9, function digit→active-low one-hot.
- Sub-module code_debounce: cand/cnt filter, outputs accept pulse + accepted raw code. Top holds FSM, display registers, event buffer, error counter.

## Test plan
- Idle after reset, I_n=4'b1010 (digit 5) held 4 cycles → after 4th edge O_n=10'b11_1101_1111, O_digit=5, O_key_vld=1, code=5, rel=0. I_key_rdy=1 → vld clears next edge.
- I_n=4'b1010 for 2 cycles, then 4'b1111 → no output change, no event.
- Digit 5 accepted, then 4'b1111 held 4 cycles → O_n=10'b11_1111_1110, O_digit=0, event code=5, rel=1.
- I_n=4'b0011 (digit 12) held 4 cycles → O_err pulse, O_err_cnt=1, O_n unchanged. Repeat 300 runs with ERR_W=8 → O_err_cnt holds 255.
- I_key_rdy=0: press 5, then press 3 → O_key_code stays 5, O_ovf=1, O_digit=3. Then I_key_rdy=1 → vld clears, O_ovf stays 1.
- Press 7 accepted with event pending, I_rst pulsed mid-debounce of next code → all outputs at reset values; no event after release.

Source files
------------

// File: rtl/bcd_key_decoder_pkg.sv
// Shared types and helpers for the complemented-BCD keypad decoder.
package keydec_pkg;

  typedef enum logic {S_IDLE, S_PRESS} state_t;

  localparam logic [3:0] CODE_NONE = 4'b1111;
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  // Active-low one-hot: bit d low, all others high.
  function automatic logic [9:0] digit_to_onehot_n(input logic [3:0] d);
    return ~(10'd1 << d);
  endfunction

endpackage

// File: rtl/bcd_key_decoder_if.sv
// Signal bundle between the keypad encoder/consumer side and the decoder.
interface bcd_key_decoder_if #(
  parameter int ERR_W = 8
);
  logic [3:0]       I_n;
  logic [9:0]       O_n;
  logic [3:0]       O_digit;
  logic             O_key_vld;
  logic [3:0]       O_key_code;
  logic             O_key_rel;
  logic             I_key_rdy;
  logic             O_err;
  logic [ERR_W-1:0] O_err_cnt;
  logic             O_ovf;

  modport slave (
    input  I_n, I_key_rdy,
    output O_n, O_digit, O_key_vld, O_key_code, O_key_rel, O_err, O_err_cnt, O_ovf
  );

  modport master (
    output I_n, I_key_rdy,
    input  O_n, O_digit, O_key_vld, O_key_code, O_key_rel, O_err, O_err_cnt, O_ovf
  );
endinterface

// File: rtl/bcd_key_decoder_code_debounce.sv
// Stability filter: a code must be sampled STABLE_CYCLES times in a row before it is accepted once.
module code_debounce
  import keydec_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] code,
  output logic       accept,
  output logic [3:0] acc_code
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [3:0]    cand_reg;
  logic [CW-1:0] cnt_reg;

  // Reset to a saturated "no key" run so nothing is accepted coming out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_reg <= CODE_NONE;
      cnt_reg  <= FULL;
    end else if (code != cand_reg) begin
      cand_reg <= code;
      cnt_reg  <= CW'(1);
    end else if (cnt_reg < FULL) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Accept on the edge that completes the run; the top registers the result.
  assign accept   = (code == cand_reg) && (cnt_reg == LAST);
  assign acc_code = cand_reg;

endmodule

// File: rtl/bcd_key_decoder.sv
// Decodes debounced complemented-BCD keypad codes into display lines, a digit and press/release events.
module bcd_key_decoder
  import keydec_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input logic               I_clk,
  input logic               I_rst,
  bcd_key_decoder_if.slave  kif
);

  logic       accept;
  logic [3:0] acc_code;

  code_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_debounce (
    .clk      (I_clk),
    .rst      (I_rst),
    .code     (kif.I_n),
    .accept   (accept),
    .acc_code (acc_code)
  );

  state_t           state_reg, state_next;
  logic [3:0]       digit_reg, digit_next;
  logic [9:0]       onehot_reg, onehot_next;
  logic             vld_reg, vld_next;
  logic [3:0]       code_reg, code_next;
  logic             rel_reg, rel_next;
  logic             err_reg, err_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;
  logic             ovf_reg, ovf_next;

  logic [3:0] d;
  logic       evt;
  logic [3:0] evt_code;
  logic       evt_rel;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_reg   <= S_IDLE;
      digit_reg   <= 4'd0;
      onehot_reg  <= digit_to_onehot_n(4'd0);
      vld_reg     <= 1'b0;
      code_reg    <= 4'd0;
      rel_reg     <= 1'b0;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      digit_reg   <= digit_next;
      onehot_reg  <= onehot_next;
      vld_reg     <= vld_next;
      code_reg    <= code_next;
      rel_reg     <= rel_next;
      err_reg     <= err_next;
      err_cnt_reg <= err_cnt_next;
      ovf_reg     <= ovf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    digit_next   = digit_reg;
    onehot_next  = onehot_reg;
    vld_next     = vld_reg;
    code_next    = code_reg;
    rel_next     = rel_reg;
    err_next     = 1'b0;
    err_cnt_next = err_cnt_reg;
    ovf_next     = ovf_reg;
    evt          = 1'b0;
    evt_code     = 4'd0;
    evt_rel      = 1'b0;
    d            = ~acc_code;

    if (accept) begin
      if (d > MAX_DIGIT) begin
        err_next = 1'b1;
        if (err_cnt_reg != '1)
          err_cnt_next = err_cnt_reg + 1'b1;
      end else if (d != digit_reg) begin
        // Re-accepting the shown digit is ignored so a glitch that returns is silent.
        digit_next  = d;
        onehot_next = digit_to_onehot_n(d);
        evt         = 1'b1;
        case (state_reg)
          S_IDLE: begin
            state_next = S_PRESS;
            evt_code   = d;
          end
          S_PRESS: begin
            if (d == 4'd0) begin
              state_next = S_IDLE;
              evt_code   = digit_reg;
              evt_rel    = 1'b1;
            end else begin
              evt_code   = d;
            end
          end
          default: state_next = S_IDLE;
        endcase
      end
    end

    // A completing handshake frees the slot in time for a same-edge event.
    if (evt) begin
      if (vld_reg && !kif.I_key_rdy) begin
        ovf_next = 1'b1;
      end else begin
        vld_next  = 1'b1;
        code_next = evt_code;
        rel_next  = evt_rel;
      end
    end else if (vld_reg && kif.I_key_rdy) begin
      vld_next = 1'b0;
    end
  end

  assign kif.O_n        = onehot_reg;
  assign kif.O_digit    = digit_reg;
  assign kif.O_key_vld  = vld_reg;
  assign kif.O_key_code = code_reg;
  assign kif.O_key_rel  = rel_reg;
  assign kif.O_err      = err_reg;
  assign kif.O_err_cnt  = err_cnt_reg;
  assign kif.O_ovf      = ovf_reg;

endmodule

// File: tb/tb_bcd_key_decoder.sv
// Directed bench for bcd_key_decoder with an event scoreboard queue.
module tb_bcd_key_decoder;
  import keydec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_key_decoder_if #(.ERR_W(8)) kif ();

  bcd_key_decoder #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .kif   (kif.slave)
  );

  typedef struct packed {
    logic [3:0] code;
    logic       rel;
  } evt_t;

  evt_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] c, input int n);
    kif.I_n = c;
    repeat (n) step();
  endtask

  task automatic push(input logic [3:0] c, input logic r);
    evt_t e;
    e.code = c;
    e.rel  = r;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for an event, compares it with the queue head, then handshakes it away.
  task automatic consume(input string tag);
    int   waited = 0;
    evt_t e = '0;
    while (kif.O_key_vld !== 1'b1 && waited < 8) begin
      step();
      waited++;
    end
    chk({tag, "_vld"}, 32'(kif.O_key_vld), 32'd1);
    chk({tag, "_qnonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk({tag, "_code"}, 32'(kif.O_key_code), 32'(e.code));
    chk({tag, "_rel"}, 32'(kif.O_key_rel), 32'(e.rel));
    $display("[TB] %s: event code=%0d rel=%0d", tag, kif.O_key_code, kif.O_key_rel);
    kif.I_key_rdy = 1'b1;
    step();
    kif.I_key_rdy = 1'b0;
    chk({tag, "_cleared"}, 32'(kif.O_key_vld), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_O_n"}, 32'(kif.O_n), 32'(10'b11_1111_1110));
    chk({tag, "_digit"}, 32'(kif.O_digit), 32'd0);
    chk({tag, "_vld"}, 32'(kif.O_key_vld), 32'd0);
    chk({tag, "_code"}, 32'(kif.O_key_code), 32'd0);
    chk({tag, "_rel"}, 32'(kif.O_key_rel), 32'd0);
    chk({tag, "_err"}, 32'(kif.O_err), 32'd0);
    chk({tag, "_err_cnt"}, 32'(kif.O_err_cnt), 32'd0);
    chk({tag, "_ovf"}, 32'(kif.O_ovf), 32'd0);
  endtask

  initial begin
    evt_t head;
    kif.I_n       = 4'b1111;
    kif.I_key_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");
    $display("[TB] reset released");

    // Press 5: no change after 3 edges, accepted on the 4th.
    hold(4'b1010, 3);
    chk("latency_digit", 32'(kif.O_digit), 32'd0);
    chk("latency_vld", 32'(kif.O_key_vld), 32'd0);
    hold(4'b1010, 1);
    chk("press5_O_n", 32'(kif.O_n), 32'(10'b11_1101_1111));
    chk("press5_digit", 32'(kif.O_digit), 32'd5);
    push(4'd5, 1'b0);
    consume("press5");

    // Release 5.
    hold(4'b1111, 4);
    chk("rel5_O_n", 32'(kif.O_n), 32'(10'b11_1111_1110));
    chk("rel5_digit", 32'(kif.O_digit), 32'd0);
    push(4'd5, 1'b1);
    consume("release5");

    // Short burst that returns to idle: nothing happens.
    hold(4'b1010, 2);
    hold(4'b1111, 4);
    chk("short_digit", 32'(kif.O_digit), 32'd0);
    chk("short_vld", 32'(kif.O_key_vld), 32'd0);
    $display("[TB] short burst ignored");

    // One-cycle glitch restarts qualification.
    hold(4'b1010, 2);
    hold(4'b1111, 1);
    hold(4'b1010, 3);
    chk("glitch_requal_digit", 32'(kif.O_digit), 32'd0);
    hold(4'b1010, 1);
    chk("glitch_accept_digit", 32'(kif.O_digit), 32'd5);
    push(4'd5, 1'b0);
    consume("press5_after_glitch");

    // Direct change 5->3: single press, then release completes on the same edge as a handshake.
    hold(4'b1100, 4);
    chk("direct3_digit", 32'(kif.O_digit), 32'd3);
    push(4'd3, 1'b0);
    kif.I_n = 4'b1111;
    repeat (3) step();
    head = '0;
    if (exp_q.size() != 0) head = exp_q.pop_front();
    chk("direct3_code", 32'(kif.O_key_code), 32'(head.code));
    chk("direct3_rel", 32'(kif.O_key_rel), 32'(head.rel));
    $display("[TB] direct change: event code=%0d rel=%0d", kif.O_key_code, kif.O_key_rel);
    kif.I_key_rdy = 1'b1;
    step();
    kif.I_key_rdy = 1'b0;
    chk("sameedge_ovf", 32'(kif.O_ovf), 32'd0);
    chk("sameedge_digit", 32'(kif.O_digit), 32'd0);
    push(4'd3, 1'b1);
    consume("release3_sameedge");

    // Invalid code 12.
    hold(4'b0011, 3);
    chk("inv_before_err", 32'(kif.O_err), 32'd0);
    hold(4'b0011, 1);
    chk("inv_err", 32'(kif.O_err), 32'd1);
    chk("inv_err_cnt", 32'(kif.O_err_cnt), 32'd1);
    chk("inv_O_n", 32'(kif.O_n), 32'(10'b11_1111_1110));
    chk("inv_vld", 32'(kif.O_key_vld), 32'd0);
    step();
    chk("inv_err_pulse", 32'(kif.O_err), 32'd0);
    $display("[TB] invalid code flagged, count=%0d", kif.O_err_cnt);

    // 299 more invalid runs, alternating 11 and 12, must saturate at 255.
    for (int i = 0; i < 299; i++) begin
      hold((i % 2 == 0) ? 4'b0100 : 4'b0011, 4);
      if (i == 252) chk("err_cnt_254", 32'(kif.O_err_cnt), 32'd254);
    end
    chk("err_cnt_sat", 32'(kif.O_err_cnt), 32'd255);
    chk("err_state_digit", 32'(kif.O_digit), 32'd0);
    hold(4'b1111, 4);
    chk("err_sat_hold", 32'(kif.O_err_cnt), 32'd255);
    chk("err_no_event", 32'(kif.O_key_vld), 32'd0);
    $display("[TB] error counter saturated at %0d", kif.O_err_cnt);

    // Overflow: press 5 unconsumed, then press 3 is dropped.
    hold(4'b1010, 4);
    push(4'd5, 1'b0);
    chk("ovf_before", 32'(kif.O_ovf), 32'd0);
    hold(4'b1100, 4);
    chk("ovf_code_held", 32'(kif.O_key_code), 32'd5);
    chk("ovf_rel_held", 32'(kif.O_key_rel), 32'd0);
    chk("ovf_flag", 32'(kif.O_ovf), 32'd1);
    chk("ovf_digit", 32'(kif.O_digit), 32'd3);
    chk("ovf_O_n", 32'(kif.O_n), 32'(10'b11_1111_0111));
    consume("ovf_press5");
    chk("ovf_sticky", 32'(kif.O_ovf), 32'd1);
    hold(4'b1111, 4);
    push(4'd3, 1'b1);
    consume("release3");

    // Press 7 pending, reset mid-debounce of next code.
    hold(4'b1000, 4);
    chk("press7_digit", 32'(kif.O_digit), 32'd7);
    chk("press7_vld", 32'(kif.O_key_vld), 32'd1);
    kif.I_n = 4'b1100;
    repeat (2) step();
    rst = 1'b1;
    #1;
    chk_reset_vals("midreset");
    kif.I_n = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    hold(4'b1111, 6);
    chk("post_reset_vld", 32'(kif.O_key_vld), 32'd0);
    chk("post_reset_digit", 32'(kif.O_digit), 32'd0);
    $display("[TB] reset with pending event: no spurious release");

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
